// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: nested column/row counters, sync pulses,
// active-video and start strobes, and a wrapping frame counter.
module vga_sync_gen #(
    parameter int   c_TOTAL_COLS   = 800,
    parameter int   c_TOTAL_ROWS   = 525,
    parameter int   c_ACTIVE_COLS  = 640,
    parameter int   c_ACTIVE_ROWS  = 480,
    parameter int   c_H_FRONT_PORCH = 16,
    parameter int   c_H_SYNC_WIDTH = 96,
    parameter int   c_V_FRONT_PORCH = 10,
    parameter int   c_V_SYNC_WIDTH = 2,
    parameter logic c_SYNC_ACTIVE  = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Line_Start,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count
);

    localparam logic [9:0] LAST_COL   = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW   = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS   = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS   = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] HS_FIRST   = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [9:0] HS_LAST    = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH - 1);
    localparam logic [9:0] VS_FIRST   = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [9:0] VS_LAST    = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH - 1);

    logic [9:0] col_nxt;
    logic [9:0] row_nxt;
    logic       col_wrap;
    logic       frame_wrap;
    logic       running;

    // Decode from the next counter values so syncs and strobes line up with the counts.
    always_comb begin
        col_wrap   = (o_Col_Count == LAST_COL);
        frame_wrap = col_wrap && (o_Row_Count == LAST_ROW);
        col_nxt    = col_wrap ? 10'd0 : o_Col_Count + 10'd1;
        row_nxt    = o_Row_Count;
        if (col_wrap) begin
            row_nxt = (o_Row_Count == LAST_ROW) ? 10'd0 : o_Row_Count + 10'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Col_Count   <= LAST_COL;
            o_Row_Count   <= LAST_ROW;
            o_HSync       <= ~c_SYNC_ACTIVE;
            o_VSync       <= ~c_SYNC_ACTIVE;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Frame_Count <= 8'd0;
            running       <= 1'b0;
        end else begin
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_HSync       <= (col_nxt >= HS_FIRST && col_nxt <= HS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
            o_VSync       <= (row_nxt >= VS_FIRST && row_nxt <= VS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
            o_Active      <= (col_nxt < ACT_COLS) && (row_nxt < ACT_ROWS);
            o_Line_Start  <= (col_nxt == 10'd0);
            o_Frame_Start <= (col_nxt == 10'd0) && (row_nxt == 10'd0);
            running       <= 1'b1;
            // The wrap out of the reset position is not a completed frame.
            if (frame_wrap && running) begin
                o_Frame_Count <= o_Frame_Count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-size and reduced-size instances (both sync polarities)
// checked every cycle against an arithmetic raster model driven by cycles since reset.
module tb_vga_sync_gen;

    typedef struct {
        int   c; int r; int ac; int ar;
        int   hfp; int hsw; int vfp; int vsw;
        logic sa;
    } cfg_t;

    typedef struct {
        logic       hs; logic vs;
        logic [9:0] col; logic [9:0] row;
        logic       act; logic ls; logic fs;
        logic [7:0] fc;
    } exp_t;

    localparam cfg_t DEF = '{c:800, r:525, ac:640, ar:480, hfp:16, hsw:96, vfp:10, vsw:2, sa:1'b0};
    localparam cfg_t SML = '{c:16, r:10, ac:10, ar:6, hfp:2, hsw:3, vfp:1, vsw:2, sa:1'b0};
    localparam cfg_t INV = '{c:16, r:10, ac:10, ar:6, hfp:2, hsw:3, vfp:1, vsw:2, sa:1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_col, s_row;
    logic [7:0] s_fc;
    logic       v_hs, v_vs, v_act, v_ls, v_fs;
    logic [9:0] v_col, v_row;
    logic [7:0] v_fc;

    vga_sync_gen dut_def (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(d_hs), .o_VSync(d_vs),
        .o_Col_Count(d_col), .o_Row_Count(d_row), .o_Active(d_act),
        .o_Line_Start(d_ls), .o_Frame_Start(d_fs), .o_Frame_Count(d_fc)
    );

    vga_sync_gen #(
        .c_TOTAL_COLS(16), .c_TOTAL_ROWS(10), .c_ACTIVE_COLS(10), .c_ACTIVE_ROWS(6),
        .c_H_FRONT_PORCH(2), .c_H_SYNC_WIDTH(3), .c_V_FRONT_PORCH(1), .c_V_SYNC_WIDTH(2),
        .c_SYNC_ACTIVE(1'b0)
    ) dut_sml (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(s_hs), .o_VSync(s_vs),
        .o_Col_Count(s_col), .o_Row_Count(s_row), .o_Active(s_act),
        .o_Line_Start(s_ls), .o_Frame_Start(s_fs), .o_Frame_Count(s_fc)
    );

    vga_sync_gen #(
        .c_TOTAL_COLS(16), .c_TOTAL_ROWS(10), .c_ACTIVE_COLS(10), .c_ACTIVE_ROWS(6),
        .c_H_FRONT_PORCH(2), .c_H_SYNC_WIDTH(3), .c_V_FRONT_PORCH(1), .c_V_SYNC_WIDTH(2),
        .c_SYNC_ACTIVE(1'b1)
    ) dut_inv (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(v_hs), .o_VSync(v_vs),
        .o_Col_Count(v_col), .o_Row_Count(v_row), .o_Active(v_act),
        .o_Line_Start(v_ls), .o_Frame_Start(v_fs), .o_Frame_Count(v_fc)
    );

    int vectors = 0;
    int miscompares = 0;
    int n = -1;  // cycles since the first edge after reset release; -1 while in reset

    // Raster position follows directly from elapsed cycles.
    function automatic exp_t model(cfg_t g, int k);
        exp_t e;
        int col, row;
        if (k < 0) begin
            e.col = 10'(g.c - 1); e.row = 10'(g.r - 1);
            e.hs = ~g.sa; e.vs = ~g.sa;
            e.act = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
        end else begin
            col = k % g.c;
            row = (k / g.c) % g.r;
            e.col = 10'(col); e.row = 10'(row);
            e.hs  = (col >= g.ac + g.hfp && col < g.ac + g.hfp + g.hsw) ? g.sa : ~g.sa;
            e.vs  = (row >= g.ar + g.vfp && row < g.ar + g.vfp + g.vsw) ? g.sa : ~g.sa;
            e.act = (col < g.ac) && (row < g.ar);
            e.ls  = (col == 0);
            e.fs  = (col == 0) && (row == 0);
            e.fc  = 8'((k / (g.c * g.r)) % 256);
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_dut(string name, cfg_t g, logic hs, logic vs, logic [9:0] col,
                             logic [9:0] row, logic act, logic ls, logic fs, logic [7:0] fc);
        exp_t e;
        e = model(g, n);
        chk({name, "_col"}, 32'(col), 32'(e.col));
        chk({name, "_row"}, 32'(row), 32'(e.row));
        chk({name, "_hsync"}, 32'(hs), 32'(e.hs));
        chk({name, "_vsync"}, 32'(vs), 32'(e.vs));
        chk({name, "_active"}, 32'(act), 32'(e.act));
        chk({name, "_line_start"}, 32'(ls), 32'(e.ls));
        chk({name, "_frame_start"}, 32'(fs), 32'(e.fs));
        chk({name, "_frame_count"}, 32'(fc), 32'(e.fc));
    endtask

    task automatic run(int cycles);
        logic r;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            r = rst;
            #1;
            n = r ? -1 : n + 1;
            check_dut("def", DEF, d_hs, d_vs, d_col, d_row, d_act, d_ls, d_fs, d_fc);
            check_dut("sml", SML, s_hs, s_vs, s_col, s_row, s_act, s_ls, s_fs, s_fc);
            check_dut("inv", INV, v_hs, v_vs, v_col, v_row, v_act, v_ls, v_fs, v_fc);
        end
    endtask

    initial begin
        // Reset held 5 cycles, then release.
        rst = 1'b1;
        run(5);
        chk("rst_def_col", 32'(d_col), 32'd799);
        chk("rst_def_row", 32'(d_row), 32'd524);
        chk("rst_def_hsync", 32'(d_hs), 32'd1);
        chk("rst_inv_hsync", 32'(v_hs), 32'd0);
        rst = 1'b0;
        run(1);
        chk("exit_def_col", 32'(d_col), 32'd0);
        chk("exit_def_frame_start", 32'(d_fs), 32'd1);
        chk("exit_def_frame_count", 32'(d_fc), 32'd0);

        // A couple of small frames plus a random tail.
        run(2 * 160 + $urandom_range(0, 159));

        // Reset while the small raster is in both syncs at (col 13, row 8).
        for (int k = 0; k < 400 && !(n >= 0 && (n % 160) == 141); k++) run(1);
        chk("reach_midframe", 32'(n % 160), 32'd141);
        chk("mid_sml_hsync_on", 32'(s_hs), 32'd0);
        chk("mid_sml_vsync_on", 32'(s_vs), 32'd0);
        rst = 1'b1;
        run(1);
        chk("mid_sml_col", 32'(s_col), 32'd15);
        chk("mid_sml_row", 32'(s_row), 32'd9);
        chk("mid_sml_hsync_off", 32'(s_hs), 32'd1);
        run($urandom_range(0, 3));
        rst = 1'b0;
        run(400);

        // Resets at random points, random lengths.
        for (int j = 0; j < 4; j++) begin
            run($urandom_range(50, 700));
            rst = 1'b1;
            run($urandom_range(1, 4));
            rst = 1'b0;
        end

        // Long run: the small raster wraps its frame counter past 255.
        run(257 * 160 + $urandom_range(0, 159));
        chk("long_sml_frame_count", 32'(s_fc), 32'(8'(n / 160)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
